dmem_resp: RTL and testbench

Data-memory responder for the execute stage's data SRAM port. It decodes the load and store controls, address and write data that the execute stage drives each cycle, and holds the word-organised data array. It returns load data combinationally in the same cycle, with byte/half-word extraction and sign extension, and commits stores on the clock edge. It also zero-fills the array after reset, flags misaligned or out-of-range stores, and counts committed stores.

---
 rtl/dmem_resp.sv | 165 ++++++++++++++++
 tb/tb_dmem_resp.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_resp.sv
// Data-memory responder: word-organised array with combinational sub-word loads,
// byte-lane stores, post-reset zero-fill, sticky store-error capture and a store counter.
module dmem_resp #(
   parameter int              XLEN     = 32,
   parameter int              DEPTH    = 1024,
   parameter logic [XLEN-1:0] MEM_BASE = 32'h8000_0000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [2:0]      data_sram_rd_ctrl,
   input  logic [1:0]      data_sram_wr_ctrl,
   input  logic [XLEN-1:0] data_sram_addr,
   input  logic [XLEN-1:0] data_sram_wdata,
   output logic [XLEN-1:0] data_sram_rdata,
   output logic            init_done,
   output logic            err_valid,
   output logic [XLEN-1:0] err_addr,
   input  logic            err_clr,
   output logic [31:0]     store_cnt
);

   localparam int AW = $clog2(DEPTH);
   localparam int NB = XLEN / 8;
   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE  = AW'(1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t            state;
   state_t            state_next;
   logic [AW-1:0]     ptr;
   logic              clear_we;

   logic [XLEN-1:0]   mem [DEPTH];

   logic [XLEN-1:0]   off;
   logic              in_range;
   logic [AW-1:0]     idx;
   logic [1:0]        lane;

   logic              rd_mis;
   logic              wr_mis;
   logic [XLEN-1:0]   rd_word;
   logic [XLEN-1:0]   byte_shift;
   logic [XLEN-1:0]   half_shift;
   logic [7:0]        rd_byte;
   logic [15:0]       rd_half;

   logic              store_req;
   logic              store_ok;
   logic              store_fault;
   logic [NB-1:0]     wmask;
   logic [XLEN-1:0]   wword;

   // DEPTH is a power of two, so the range check is just "no offset bits above the array"
   assign off      = data_sram_addr - MEM_BASE;
   assign in_range = (off[XLEN-1:AW+2] == '0);
   assign idx      = off[AW+1:2];
   assign lane     = off[1:0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_next;
         if (clear_we) ptr <= ptr + PTR_ONE;
      end
   end

   always_comb begin
      state_next = state;
      if (state == CLEAR && ptr == PTR_LAST) state_next = READY;
   end

   always_comb begin
      init_done = (state == READY);
      clear_we  = (state == CLEAR);
   end

   always_comb begin
      rd_mis = 1'b0;
      case (data_sram_rd_ctrl)
         3'b011, 3'b100: rd_mis = off[0];
         3'b101:         rd_mis = (off[1:0] != 2'b00);
         default:        rd_mis = 1'b0;
      endcase
   end

   assign rd_word    = mem[idx];
   assign byte_shift = rd_word >> {lane, 3'b000};
   assign half_shift = rd_word >> {off[1], 4'b0000};
   assign rd_byte    = byte_shift[7:0];
   assign rd_half    = half_shift[15:0];

   always_comb begin
      data_sram_rdata = '0;
      if (init_done && in_range && !rd_mis) begin
         case (data_sram_rd_ctrl)
            3'b001:  data_sram_rdata = {{(XLEN-8){rd_byte[7]}}, rd_byte};
            3'b010:  data_sram_rdata = {{(XLEN-8){1'b0}}, rd_byte};
            3'b011:  data_sram_rdata = {{(XLEN-16){rd_half[15]}}, rd_half};
            3'b100:  data_sram_rdata = {{(XLEN-16){1'b0}}, rd_half};
            3'b101:  data_sram_rdata = rd_word;
            default: data_sram_rdata = '0;
         endcase
      end
   end

   always_comb begin
      wr_mis = 1'b0;
      wmask  = '0;
      wword  = data_sram_wdata;
      case (data_sram_wr_ctrl)
         2'b01: begin
            wmask = {{(NB-1){1'b0}}, 1'b1} << lane;
            wword = {NB{data_sram_wdata[7:0]}};
         end
         2'b10: begin
            wr_mis = off[0];
            wmask  = {{(NB-2){1'b0}}, 2'b11} << {off[1], 1'b0};
            wword  = {(NB/2){data_sram_wdata[15:0]}};
         end
         2'b11: begin
            wr_mis = (off[1:0] != 2'b00);
            wmask  = '1;
         end
         default: ;
      endcase
   end

   // Stores are ignored entirely until the zero-fill pass has finished
   assign store_req   = init_done && (data_sram_wr_ctrl != 2'b00);
   assign store_ok    = store_req && in_range && !wr_mis;
   assign store_fault = store_req && !(in_range && !wr_mis);

   always_ff @(posedge clk) begin
      if (clear_we) begin
         mem[ptr] <= '0;
      end else if (store_ok) begin
         for (int b = 0; b < NB; b++) begin
            if (wmask[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
         end
      end
   end

   // err_clr takes priority so a fault landing on the clearing edge is dropped
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_valid <= 1'b0;
         err_addr  <= '0;
         store_cnt <= '0;
      end else begin
         if (err_clr) begin
            err_valid <= 1'b0;
            err_addr  <= '0;
         end else if (store_fault && !err_valid) begin
            err_valid <= 1'b1;
            err_addr  <= data_sram_addr;
         end
         if (store_ok) store_cnt <= store_cnt + 32'd1;
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp with a 16-word array: zero-fill timing, lane loads/stores,
// store faults and error clearing, range checks, and reset during the clear pass.
module tb_dmem_resp;

   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int          DEPTH = 16;

   logic        clk;
   logic        rst;
   logic [2:0]  rd_ctrl;
   logic [1:0]  wr_ctrl;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        init_done;
   logic        err_valid;
   logic [31:0] err_addr;
   logic        err_clr;
   logic [31:0] store_cnt;

   int checks   = 0;
   int failures = 0;

   dmem_resp #(.XLEN(32), .DEPTH(DEPTH), .MEM_BASE(BASE)) dut (
      .clk               (clk),
      .rst               (rst),
      .data_sram_rd_ctrl (rd_ctrl),
      .data_sram_wr_ctrl (wr_ctrl),
      .data_sram_addr    (addr),
      .data_sram_wdata   (wdata),
      .data_sram_rdata   (rdata),
      .init_done         (init_done),
      .err_valid         (err_valid),
      .err_addr          (err_addr),
      .err_clr           (err_clr),
      .store_cnt         (store_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input logic [2:0] rd, input logic [1:0] wr,
                                 input logic [31:0] a, input logic [31:0] d);
      rd_ctrl = rd;
      wr_ctrl = wr;
      addr    = a;
      wdata   = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic load_check(input string tag, input logic [2:0] rd, input logic [31:0] a,
                             input logic [31:0] exp);
      apply_stimulus(rd, 2'b00, a, 32'h0);
      #1;
      check_output(tag, rdata, exp);
   endtask

   initial begin
      rst     = 1'b0;
      err_clr = 1'b0;
      apply_stimulus(3'b101, 2'b00, BASE, 32'h0);
      #2;
      check_output("reset_init_done", {31'b0, init_done}, 32'd0);
      check_output("reset_err_valid", {31'b0, err_valid}, 32'd0);
      check_output("reset_err_addr", err_addr, 32'h0);
      check_output("reset_store_cnt", store_cnt, 32'd0);
      check_output("reset_rdata", rdata, 32'h0);

      #20;
      rst = 1'b1;
      for (int k = 1; k <= DEPTH; k++) begin
         step();
         check_output($sformatf("init_done_edge%0d", k), {31'b0, init_done}, (k == DEPTH) ? 32'd1 : 32'd0);
      end
      load_check("lw_last_word_zero", 3'b101, BASE + 32'h3C, 32'h0);

      // same-cycle load sees old data, next cycle sees the store
      apply_stimulus(3'b101, 2'b11, BASE, 32'h8765_4321);
      #1;
      check_output("lw_during_sw_old", rdata, 32'h0);
      step();
      load_check("lw_after_sw", 3'b101, BASE, 32'h8765_4321);
      check_output("cnt_after_sw", store_cnt, 32'd1);
      load_check("lb_plus3", 3'b001, BASE + 32'd3, 32'hFFFF_FF87);
      load_check("lbu_plus3", 3'b010, BASE + 32'd3, 32'h0000_0087);
      load_check("lh_plus2", 3'b011, BASE + 32'd2, 32'hFFFF_8765);
      load_check("lhu_plus0", 3'b100, BASE, 32'h0000_4321);
      load_check("lh_misaligned", 3'b011, BASE + 32'd1, 32'h0);
      load_check("lw_misaligned", 3'b101, BASE + 32'd2, 32'h0);
      load_check("rd_ctrl_110", 3'b110, BASE, 32'h0);

      apply_stimulus(3'b000, 2'b01, BASE + 32'd1, 32'h0000_00AA);
      step();
      load_check("lw_after_sb", 3'b101, BASE, 32'h8765_AA21);
      check_output("cnt_after_sb", store_cnt, 32'd2);

      apply_stimulus(3'b000, 2'b10, BASE + 32'd5, 32'h0000_BEEF);
      step();
      check_output("sh_mis_err_valid", {31'b0, err_valid}, 32'd1);
      check_output("sh_mis_err_addr", err_addr, 32'h8000_0005);
      check_output("sh_mis_cnt", store_cnt, 32'd2);
      load_check("sh_mis_word1_kept", 3'b101, BASE + 32'd4, 32'h0);

      apply_stimulus(3'b000, 2'b11, BASE + 32'd6, 32'h1234_5678);
      step();
      check_output("second_fault_err_addr", err_addr, 32'h8000_0005);
      check_output("second_fault_err_valid", {31'b0, err_valid}, 32'd1);
      check_output("second_fault_cnt", store_cnt, 32'd2);

      apply_stimulus(3'b000, 2'b00, BASE, 32'h0);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_output("clr_err_valid", {31'b0, err_valid}, 32'd0);
      check_output("clr_err_addr", err_addr, 32'h0);

      apply_stimulus(3'b000, 2'b10, BASE + 32'd5, 32'h0000_BEEF);
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      check_output("clr_wins_err_valid", {31'b0, err_valid}, 32'd0);
      check_output("clr_wins_err_addr", err_addr, 32'h0);

      apply_stimulus(3'b000, 2'b11, BASE + 32'h3C, 32'hCAFE_F00D);
      step();
      check_output("cnt_after_top_sw", store_cnt, 32'd3);

      apply_stimulus(3'b000, 2'b11, BASE + 32'h40, 32'h1234_5678);
      step();
      check_output("oor_err_valid", {31'b0, err_valid}, 32'd1);
      check_output("oor_err_addr", err_addr, 32'h8000_0040);
      check_output("oor_cnt", store_cnt, 32'd3);
      load_check("oor_word0_kept", 3'b101, BASE, 32'h8765_AA21);
      load_check("lw_below_base", 3'b101, BASE - 32'd4, 32'h0);
      load_check("lw_top_word", 3'b101, BASE + 32'h3C, 32'hCAFE_F00D);

      // reset during READY, then again five cycles into the clear pass
      rst = 1'b0;
      #1;
      check_output("rst2_init_done", {31'b0, init_done}, 32'd0);
      check_output("rst2_store_cnt", store_cnt, 32'd0);
      check_output("rst2_err_valid", {31'b0, err_valid}, 32'd0);
      check_output("rst2_rdata", rdata, 32'h0);
      #2;
      rst = 1'b1;
      for (int k = 1; k <= 5; k++) step();
      rst = 1'b0;
      #2;
      rst = 1'b1;
      apply_stimulus(3'b000, 2'b11, BASE, 32'h1111_1111);
      for (int k = 1; k <= DEPTH; k++) begin
         step();
         check_output($sformatf("reinit_done_edge%0d", k), {31'b0, init_done}, (k == DEPTH) ? 32'd1 : 32'd0);
         if (k == 8) apply_stimulus(3'b000, 2'b11, BASE + 32'd2, 32'h2222_2222);
         if (k == DEPTH - 1) apply_stimulus(3'b000, 2'b00, BASE, 32'h0);
      end
      check_output("preinit_store_cnt", store_cnt, 32'd0);
      check_output("preinit_err_valid", {31'b0, err_valid}, 32'd0);
      load_check("reinit_word0_zero", 3'b101, BASE, 32'h0);
      load_check("reinit_top_zero", 3'b101, BASE + 32'h3C, 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
